// File: rtl/mat_mult_2x2_seq.sv
// 2x2 matrix multiplier: collects A and B row-major, computes C = A x B on one MAC, streams C out.
// Define MAT_SIGNED_EN for two's-complement operands; default build is unsigned.
module mat_mult_2x2_seq #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 2*DATA_W+1
) (
   input  logic              i_clk,
   input  logic              i_clk_e,
   input  logic              i_rst_n,
   input  logic              s_axis_a_valid,
   output logic              s_axis_a_ready,
   input  logic [DATA_W-1:0] s_axis_a_data,
   input  logic              s_axis_b_valid,
   output logic              s_axis_b_ready,
   input  logic [DATA_W-1:0] s_axis_b_data,
   output logic              m_axis_c_valid,
   input  logic              m_axis_c_ready,
   output logic [ACC_W-1:0]  m_axis_c_data,
   output logic              m_axis_c_last,
   output logic              o_busy
);

   typedef enum logic [1:0] {ST_LOAD, ST_COMPUTE, ST_OUTPUT} state_t;

   state_t              state_q;
   logic [2:0]          a_cnt_q, b_cnt_q, step_q;
   logic [1:0]          out_idx_q;
   logic [DATA_W-1:0]   a_q [4];
   logic [DATA_W-1:0]   b_q [4];
   logic [ACC_W-1:0]    c_q [4];
   logic [ACC_W-1:0]    acc_q;

   logic [2:0]          a_cnt_d, b_cnt_d;
   logic [ACC_W-1:0]    acc_d, prod;
   logic [2*DATA_W-1:0] mul;
   logic [DATA_W-1:0]   a_op, b_op;
   logic                a_fire, b_fire, c_fire;

   assign s_axis_a_ready = (state_q == ST_LOAD) && (a_cnt_q < 3'd4);
   assign s_axis_b_ready = (state_q == ST_LOAD) && (b_cnt_q < 3'd4);
   assign m_axis_c_valid = (state_q == ST_OUTPUT);
   assign m_axis_c_data  = (state_q == ST_OUTPUT) ? c_q[out_idx_q] : '0;
   assign m_axis_c_last  = (state_q == ST_OUTPUT) && (out_idx_q == 2'd3);
   assign o_busy         = (state_q != ST_LOAD);

   // step = {i, j, k}: A indexed by {i,k}, B by {k,j}, C by {i,j}
   always_comb begin
      a_fire  = s_axis_a_valid && s_axis_a_ready && i_clk_e;
      b_fire  = s_axis_b_valid && s_axis_b_ready && i_clk_e;
      c_fire  = m_axis_c_valid && m_axis_c_ready && i_clk_e;
      a_cnt_d = a_cnt_q + {2'b00, a_fire};
      b_cnt_d = b_cnt_q + {2'b00, b_fire};
      a_op    = a_q[{step_q[2], step_q[0]}];
      b_op    = b_q[{step_q[0], step_q[1]}];
`ifdef MAT_SIGNED_EN
      mul  = $signed({{DATA_W{a_op[DATA_W-1]}}, a_op}) * $signed({{DATA_W{b_op[DATA_W-1]}}, b_op});
      prod = {{(ACC_W-2*DATA_W){mul[2*DATA_W-1]}}, mul};
`else
      mul  = {{DATA_W{1'b0}}, a_op} * {{DATA_W{1'b0}}, b_op};
      prod = {{(ACC_W-2*DATA_W){1'b0}}, mul};
`endif
      acc_d = (step_q[0] ? acc_q : '0) + prod;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= ST_LOAD;
         a_cnt_q   <= '0;
         b_cnt_q   <= '0;
         step_q    <= '0;
         out_idx_q <= '0;
         acc_q     <= '0;
         for (int unsigned i = 0; i < 4; i++) begin
            a_q[i] <= '0;
            b_q[i] <= '0;
            c_q[i] <= '0;
         end
      end else if (i_clk_e) begin
         case (state_q)
            ST_LOAD: begin
               if (a_fire) a_q[a_cnt_q[1:0]] <= s_axis_a_data;
               if (b_fire) b_q[b_cnt_q[1:0]] <= s_axis_b_data;
               a_cnt_q <= a_cnt_d;
               b_cnt_q <= b_cnt_d;
               if (a_cnt_d == 3'd4 && b_cnt_d == 3'd4) begin
                  state_q <= ST_COMPUTE;
                  step_q  <= '0;
               end
            end
            ST_COMPUTE: begin
               acc_q  <= acc_d;
               step_q <= step_q + 3'd1;
               if (step_q[0]) c_q[{step_q[2], step_q[1]}] <= acc_d;
               if (step_q == 3'd7) state_q <= ST_OUTPUT;
            end
            ST_OUTPUT: begin
               if (c_fire) begin
                  out_idx_q <= out_idx_q + 2'd1;
                  if (out_idx_q == 2'd3) begin
                     state_q   <= ST_LOAD;
                     a_cnt_q   <= '0;
                     b_cnt_q   <= '0;
                     out_idx_q <= '0;
                  end
               end
            end
            default: state_q <= ST_LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_mat_mult_2x2_seq.sv
// Self-checking bench for mat_mult_2x2_seq: directed cases plus randomized jobs against a matrix model.
`timescale 1ns/1ps
module tb_mat_mult_2x2_seq;
   localparam int DW = 8;
   localparam int AW = 2*DW+1;

   logic          clk = 1'b0;
   logic          clk_e, rst_n;
   logic          s_axis_a_valid, s_axis_a_ready;
   logic [DW-1:0] s_axis_a_data;
   logic          s_axis_b_valid, s_axis_b_ready;
   logic [DW-1:0] s_axis_b_data;
   logic          m_axis_c_valid, m_axis_c_ready, m_axis_c_last, o_busy;
   logic [AW-1:0] m_axis_c_data;

   mat_mult_2x2_seq #(.DATA_W(DW), .ACC_W(AW)) dut (
      .i_clk(clk), .i_clk_e(clk_e), .i_rst_n(rst_n),
      .s_axis_a_valid(s_axis_a_valid), .s_axis_a_ready(s_axis_a_ready), .s_axis_a_data(s_axis_a_data),
      .s_axis_b_valid(s_axis_b_valid), .s_axis_b_ready(s_axis_b_ready), .s_axis_b_data(s_axis_b_data),
      .m_axis_c_valid(m_axis_c_valid), .m_axis_c_ready(m_axis_c_ready), .m_axis_c_data(m_axis_c_data),
      .m_axis_c_last(m_axis_c_last), .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   int errors = 0, checks = 0;
   logic [DW-1:0] aq[$], bq[$];
   logic [AW-1:0] expd[$], obs[$];
   logic          expl[$];
   int  ce_mode = 0, rdy_mode = 0, cyc = 0;
   bit  gap = 1'b0, a_hold = 1'b0;
   bit  a_fire_pend, b_fire_pend, pv, pv_hold, pl, post_last;
   logic [AW-1:0] pd;
   int  edge_n = 0, last_acc = 0, a_acc = 0, b_acc = 0, c_cnt = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   function automatic longint elem_val(input logic [DW-1:0] x);
      longint v;
      v = longint'(x);
`ifdef MAT_SIGNED_EN
      if (x[DW-1]) v = v - (longint'(1) << DW);
`endif
      return v;
   endfunction

   // c[i][j] = sum_k a[i][k]*b[k][j], reduced to the result width
   function automatic logic [AW-1:0] model_c(input logic [4*DW-1:0] av, input logic [4*DW-1:0] bv,
                                             input int i, input int j);
      longint     s;
      logic [63:0] u;
      s = 0;
      for (int k = 0; k < 2; k++)
         s += elem_val(av[(i*2+k)*DW +: DW]) * elem_val(bv[(k*2+j)*DW +: DW]);
      u = s;
      return u[AW-1:0];
   endfunction

   function automatic logic [4*DW-1:0] pk(input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                                          input logic [DW-1:0] e2, input logic [DW-1:0] e3);
      return {e3, e2, e1, e0};
   endfunction

   task automatic push_job(input logic [4*DW-1:0] av, input logic [4*DW-1:0] bv);
      for (int e = 0; e < 4; e++) begin
         aq.push_back(av[e*DW +: DW]);
         bq.push_back(bv[e*DW +: DW]);
      end
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++) begin
            expd.push_back(model_c(av, bv, i, j));
            expl.push_back(i == 1 && j == 1);
         end
   endtask

   task automatic flush_all();
      aq.delete(); bq.delete(); expd.delete(); expl.delete();
      s_axis_a_valid = 1'b0;
      s_axis_b_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((aq.size() > 0 || bq.size() > 0 || expd.size() > 0 || o_busy) && n < 4000) begin
         @(posedge clk); #2;
         n++;
      end
      check({name, " completes"}, longint'(n < 4000), 1);
      if (n >= 4000) flush_all();
      repeat (3) @(posedge clk);
      #2;
   endtask

   task automatic check_obs(input string name, input int base, input longint e0, input longint e1,
                            input longint e2, input longint e3);
      longint e[4];
      e = '{e0, e1, e2, e3};
      for (int i = 0; i < 4; i++)
         if (base + i < obs.size()) check($sformatf("%s c%0d", name, i), longint'(obs[base+i]), e[i]);
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, " a_ready"}, longint'(s_axis_a_ready), 1);
      check({name, " b_ready"}, longint'(s_axis_b_ready), 1);
      check({name, " c_valid"}, longint'(m_axis_c_valid), 0);
      check({name, " c_data"},  longint'(m_axis_c_data), 0);
      check({name, " c_last"},  longint'(m_axis_c_last), 0);
      check({name, " busy"},    longint'(o_busy), 0);
   endtask

   // clock enable and output-ready patterns
   initial begin
      clk_e = 1'b1;
      m_axis_c_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         cyc++;
         case (ce_mode)
            0:       clk_e = 1'b1;
            1:       clk_e = (cyc % 2) == 0;
            default: clk_e = ($urandom_range(0, 3) != 0);
         endcase
         case (rdy_mode)
            0:       m_axis_c_ready = 1'b1;
            1:       m_axis_c_ready = ((cyc / 3) % 2) == 0;
            default: m_axis_c_ready = ($urandom_range(0, 1) == 1);
         endcase
      end
   end

   initial begin
      s_axis_a_valid = 1'b0;
      s_axis_a_data  = '0;
      forever begin
         @(posedge clk); #1;
         if (a_fire_pend && aq.size() > 0) begin
            void'(aq.pop_front());
            s_axis_a_valid = 1'b0;
         end
         if (!rst_n) s_axis_a_valid = 1'b0;
         if (!s_axis_a_valid && !a_hold && aq.size() > 0 && (!gap || $urandom_range(0, 2) != 0)) begin
            s_axis_a_valid = 1'b1;
            s_axis_a_data  = aq[0];
         end
      end
   end

   initial begin
      s_axis_b_valid = 1'b0;
      s_axis_b_data  = '0;
      forever begin
         @(posedge clk); #1;
         if (b_fire_pend && bq.size() > 0) begin
            void'(bq.pop_front());
            s_axis_b_valid = 1'b0;
         end
         if (!rst_n) s_axis_b_valid = 1'b0;
         if (!s_axis_b_valid && bq.size() > 0 && (!gap || $urandom_range(0, 2) != 0)) begin
            s_axis_b_valid = 1'b1;
            s_axis_b_data  = bq[0];
         end
      end
   end

   // compare process: outputs settle after the rising edge and are judged on the falling edge
   always @(negedge clk) begin
      bit c_f;
      if (!rst_n) begin
         pv = 0; pv_hold = 0; post_last = 0; a_fire_pend = 0; b_fire_pend = 0;
      end else begin
         if (post_last) begin
            check("busy after c11", longint'(o_busy), 0);
            check("valid after c11", longint'(m_axis_c_valid), 0);
            check("ready after c11", longint'(s_axis_a_ready && s_axis_b_ready), 1);
            post_last = 0;
         end
         if (m_axis_c_valid) begin
            if (!pv) check("latency edges", longint'(edge_n - last_acc), 8);
            if (pv_hold) begin
               check("stall data", longint'(m_axis_c_data), longint'(pd));
               check("stall last", longint'(m_axis_c_last), longint'(pl));
            end
            if (expd.size() == 0) check("unexpected valid", longint'(m_axis_c_valid), 0);
            else begin
               check("c data", longint'(m_axis_c_data), longint'(expd[0]));
               check("c last", longint'(m_axis_c_last), longint'(expl[0]));
            end
            check("busy while output", longint'(o_busy), 1);
            check("ready while output", longint'(s_axis_a_ready || s_axis_b_ready), 0);
         end
         a_fire_pend = s_axis_a_valid && s_axis_a_ready && clk_e;
         b_fire_pend = s_axis_b_valid && s_axis_b_ready && clk_e;
         c_f         = m_axis_c_valid && m_axis_c_ready && clk_e;
         if (clk_e) edge_n++;
         if (a_fire_pend || b_fire_pend) last_acc = edge_n;
         if (a_fire_pend) a_acc++;
         if (b_fire_pend) b_acc++;
         if (c_f) begin
            obs.push_back(m_axis_c_data);
            c_cnt++;
            if (expd.size() > 0) begin
               void'(expd.pop_front());
               void'(expl.pop_front());
            end
            if (m_axis_c_last) post_last = 1;
         end
         pv_hold = m_axis_c_valid && !c_f;
         pd      = m_axis_c_data;
         pl      = m_axis_c_last;
         pv      = m_axis_c_valid;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int b_base, c_base, n;
      logic [31:0] av, bv;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("reset");
      repeat (2) @(posedge clk);
      @(negedge clk); #2;
      rst_n = 1'b1;
      check_reset_outputs("after reset");

      // 1: basic product
      obs.delete();
      push_job(pk(1, 2, 3, 4), pk(5, 6, 7, 8));
      wait_idle("t1");
      check("t1 count", longint'(obs.size()), 4);
      check_obs("t1", 0, 19, 22, 43, 50);

      // 2/3: width extremes
      obs.delete();
`ifdef MAT_SIGNED_EN
      push_job(pk(8'h80, 8'h80, 8'h80, 8'h80), pk(8'h80, 8'h80, 8'h80, 8'h80));
      push_job(pk(8'hFF, 0, 0, 8'hFF), pk(3, 4, 5, 6));
      wait_idle("t3");
      check("t3 count", longint'(obs.size()), 8);
      check_obs("t3 min", 0, 32768, 32768, 32768, 32768);
      check_obs("t3 neg", 4, 'h1FFFD, 'h1FFFC, 'h1FFFB, 'h1FFFA);
`else
      push_job(pk(8'hFF, 8'hFF, 8'hFF, 8'hFF), pk(8'hFF, 8'hFF, 8'hFF, 8'hFF));
      wait_idle("t2");
      check("t2 count", longint'(obs.size()), 4);
      check_obs("t2", 0, 130050, 130050, 130050, 130050);
`endif

      // 4: B stream completes first, fifth B beat held off
      obs.delete();
      a_hold = 1'b1;
      b_base = b_acc;
      push_job(pk(1, 2, 3, 4), pk(5, 6, 7, 8));
      push_job(pk(2, 0, 1, 3), pk(4, 5, 6, 7));
      n = 0;
      while (b_acc - b_base < 4 && n < 200) begin
         @(posedge clk); #2;
         n++;
      end
      check("t4 b accepts", longint'(b_acc - b_base), 4);
      check("t4 b_ready low", longint'(s_axis_b_ready), 0);
      check("t4 still loading", longint'(o_busy), 0);
      repeat (5) @(posedge clk);
      #2;
      check("t4 fifth beat held", longint'(b_acc - b_base), 4);
      check("t4 b_ready held low", longint'(s_axis_b_ready), 0);
      a_hold = 1'b0;
      wait_idle("t4");
      check("t4 count", longint'(obs.size()), 8);
      check_obs("t4 job1", 0, 19, 22, 43, 50);
      check_obs("t4 job2", 4, 8, 10, 22, 26);

      // 5: output stalls and clock-enable gaps
      ce_mode = 1; rdy_mode = 1; gap = 1'b1;
      c_base = c_cnt;
      push_job($urandom(), $urandom());
      wait_idle("t5");
      check("t5 transfers", longint'(c_cnt - c_base), 4);

      // 6: reset during COMPUTE
      ce_mode = 0; rdy_mode = 0; gap = 1'b0;
      push_job(pk(9, 9, 9, 9), pk(7, 7, 7, 7));
      n = 0;
      while (!(o_busy && !m_axis_c_valid && edge_n - last_acc == 5) && n < 200) begin
         @(posedge clk); #2;
         n++;
      end
      check("t6 reached compute", longint'(n < 200), 1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("t6 mid reset");
      flush_all();
      @(posedge clk);
      @(negedge clk); #2;
      rst_n = 1'b1;
      obs.delete();
      push_job(pk(2, 0, 1, 3), pk(4, 5, 6, 7));
      wait_idle("t6");
      check("t6 count", longint'(obs.size()), 4);
      check_obs("t6", 0, 8, 10, 22, 26);

      // randomized jobs
      for (int r = 0; r < 8; r++) begin
         ce_mode  = $urandom_range(0, 2);
         rdy_mode = $urandom_range(0, 2);
         gap      = ($urandom_range(0, 1) == 1);
         c_base   = c_cnt;
         for (int j = 0; j < 3; j++) begin
            av = $urandom();
            bv = $urandom();
            if ($urandom_range(0, 5) == 0) av = '1;
            if ($urandom_range(0, 5) == 0) bv = {4{8'h80}};
            push_job(av, bv);
         end
         wait_idle($sformatf("rand%0d", r));
         check($sformatf("rand%0d transfers", r), longint'(c_cnt - c_base), 12);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
